// File: rtl/decode_stage.sv
// decode_stage: RV32I decode between fetch and execute; drives RegisterFile read selects and forwards writeback.
// Latency: the bundle is valid 2 cycles after accept (accept -> READ -> OUT); peak rate is one instruction per 2 cycles.
// Backpressure: in_ready is high only in IDLE or in a retiring OUT cycle; while out_ready=0 the bundle is held and its operands keep tracking writeback.
//
// Ports:
//   clk, rst (async, active-low), flush (synchronous squash)
//   in_valid/in_ready/in_instr/in_pc     : fetch handshake
//   rsel1/rsel2, rdata1/rdata2           : RegisterFile read port (1-cycle read latency)
//   wb_wen/wb_wsel/wb_wdata              : writeback snoop for forwarding
//   out_valid/out_ready, out_*           : registered decoded bundle to execute
module decode_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [RA_W-1:0] rsel1,
  output logic [RA_W-1:0] rsel2,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic            wb_wen,
  input  logic [RA_W-1:0] wb_wsel,
  input  logic [XLEN-1:0] wb_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [RA_W-1:0] out_rd,
  output logic            out_rd_wen,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_illegal
);

  typedef enum logic [1:0] {IDLE, READ, OUT} state_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;

  state_t          state_q, state_d;
  logic [XLEN-1:0] instr_q, pc_q;
  logic            fwd1_q, fwd2_q;
  logic [XLEN-1:0] byp1_q, byp2_q;

  logic            out_valid_q;
  logic [XLEN-1:0] out_pc_q, out_rs1_q, out_rs2_q, out_imm_q;
  logic [RA_W-1:0] out_rd_q;
  logic            out_rd_wen_q, out_f7b5_q, out_illegal_q;
  logic [6:0]      out_opcode_q;
  logic [2:0]      out_funct3_q;

  logic            in_ready_c;
  logic            accept;

  // Handshake and next state. Flush wins over both accept and retire.
  always_comb begin
    in_ready_c = 1'b0;
    state_d    = state_q;
    case (state_q)
      IDLE:    in_ready_c = 1'b1;
      OUT:     in_ready_c = out_ready;
      default: in_ready_c = 1'b0;
    endcase
    if (flush) in_ready_c = 1'b0;
    accept = in_valid & in_ready_c & rst;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = OUT;
      OUT:     if (out_ready) state_d = accept ? READ : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Outputs read as 0 while reset is held, including the combinational ones.
  assign in_ready = in_ready_c & rst;

  logic [RA_W-1:0] rs1_q, rs2_q, in_rs1, in_rs2;
  assign rs1_q  = instr_q[19:15];
  assign rs2_q  = instr_q[24:20];
  assign in_rs1 = in_instr[19:15];
  assign in_rs2 = in_instr[24:20];

  // The select must be live in the accept cycle so the synchronous read lands in READ.
  assign rsel1 = !rst ? '0 : (accept ? in_rs1 : rs1_q);
  assign rsel2 = !rst ? '0 : (accept ? in_rs2 : rs2_q);

  // Decode of the latched instruction, consumed in READ.
  logic [6:0]      opc;
  logic [XLEN-1:0] imm_c;
  logic            legal_c, rd_wen_c;
  assign opc = instr_q[6:0];

  always_comb begin
    imm_c   = '0;
    legal_c = 1'b1;
    case (opc)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        imm_c = {{20{instr_q[31]}}, instr_q[31:20]};
      OP_STORE:
        imm_c = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      OP_BRANCH:
        imm_c = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_c = {instr_q[31:12], 12'b0};
      OP_JAL:
        imm_c = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
      OP_REG, OP_FENCE:
        imm_c = '0;
      default:
        legal_c = 1'b0;
    endcase
    rd_wen_c = legal_c && (instr_q[11:7] != '0) &&
               !(opc inside {OP_STORE, OP_BRANCH, OP_FENCE, OP_SYSTEM});
  end

  // A writeback in the READ cycle is newer than both the bypass register and
  // the regfile data (which was read before that write landed).
  function automatic logic [XLEN-1:0] pick_op(
    input logic [RA_W-1:0] rs,
    input logic [XLEN-1:0] rdata,
    input logic            fwd,
    input logic [XLEN-1:0] byp,
    input logic            wen,
    input logic [RA_W-1:0] wsel,
    input logic [XLEN-1:0] wdata
  );
    if (rs == '0)                    pick_op = '0;
    else if (wen && (wsel == rs))    pick_op = wdata;
    else if (fwd)                    pick_op = byp;
    else                             pick_op = rdata;
  endfunction

  logic wb_hit1, wb_hit2;
  assign wb_hit1 = wb_wen && (wb_wsel != '0) && (wb_wsel == rs1_q);
  assign wb_hit2 = wb_wen && (wb_wsel != '0) && (wb_wsel == rs2_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      pc_q    <= '0;
      fwd1_q  <= 1'b0;
      fwd2_q  <= 1'b0;
      byp1_q  <= '0;
      byp2_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q <= in_instr;
        pc_q    <= in_pc;
        // The regfile returns old data for a same-cycle write, so keep the new value aside.
        fwd1_q  <= wb_wen && (wb_wsel != '0) && (wb_wsel == in_rs1);
        fwd2_q  <= wb_wen && (wb_wsel != '0) && (wb_wsel == in_rs2);
        byp1_q  <= wb_wdata;
        byp2_q  <= wb_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_rs1_q     <= '0;
      out_rs2_q     <= '0;
      out_imm_q     <= '0;
      out_rd_q      <= '0;
      out_rd_wen_q  <= 1'b0;
      out_opcode_q  <= '0;
      out_funct3_q  <= '0;
      out_f7b5_q    <= 1'b0;
      out_illegal_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        READ: begin
          out_valid_q   <= 1'b1;
          out_pc_q      <= pc_q;
          out_rs1_q     <= pick_op(rs1_q, rdata1, fwd1_q, byp1_q, wb_wen, wb_wsel, wb_wdata);
          out_rs2_q     <= pick_op(rs2_q, rdata2, fwd2_q, byp2_q, wb_wen, wb_wsel, wb_wdata);
          out_imm_q     <= imm_c;
          out_rd_q      <= instr_q[11:7];
          out_rd_wen_q  <= rd_wen_c;
          out_opcode_q  <= opc;
          out_funct3_q  <= instr_q[14:12];
          out_f7b5_q    <= instr_q[30];
          out_illegal_q <= !legal_c;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
          end else begin
            // Writeback retiring while we stall is older than this instruction.
            if (wb_hit1) out_rs1_q <= wb_wdata;
            if (wb_hit2) out_rs2_q <= wb_wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_rs1_val  = out_rs1_q;
  assign out_rs2_val  = out_rs2_q;
  assign out_imm      = out_imm_q;
  assign out_rd       = out_rd_q;
  assign out_rd_wen   = out_rd_wen_q;
  assign out_opcode   = out_opcode_q;
  assign out_funct3   = out_funct3_q;
  assign out_funct7b5 = out_f7b5_q;
  assign out_illegal  = out_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for decode_stage against a behavioural RegisterFile.
// Latency: checks that the bundle appears exactly 2 cycles after accept.
// Backpressure: exercises out_ready stalls, back-to-back accept, flush and mid-flight reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  rsel1, rsel2;
  logic [31:0] rdata1, rdata2;
  logic        wb_wen = 1'b0;
  logic [4:0]  wb_wsel = '0;
  logic [31:0] wb_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic        out_illegal;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rsel1(rsel1), .rsel2(rsel2), .rdata1(rdata1), .rdata2(rdata2),
    .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_illegal(out_illegal)
  );

  // RegisterFile model: synchronous read, old data on same-cycle read/write, x0 hardwired.
  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      rdata1 <= '0;
      rdata2 <= '0;
    end else begin
      rdata1 <= regs[rsel1];
      rdata2 <= regs[rsel2];
      if (wb_wen && wb_wsel != 5'd0) regs[wb_wsel] <= wb_wdata;
    end
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] v1;       // preset for rs1 register
    logic [31:0] v2;       // preset for rs2 register
    logic        aw;       // writeback during accept cycle
    logic [4:0]  asel;
    logic [31:0] adat;
    logic        rw;       // writeback during READ cycle
    logic [4:0]  rsel;
    logic [31:0] rdat;
    logic        chk_ops;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        chk_imm;
    logic [31:0] eimm;
    logic [4:0]  erd;
    logic        ewen;
    logic        eill;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] sel, input logic [31:0] dat);
    wb_wen = 1'b1; wb_wsel = sel; wb_wdata = dat;
    tick();
    wb_wen = 1'b0;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " in_ready"}, in_ready, 0);
    check({tag, " rsel1"}, rsel1, 0);
    check({tag, " rsel2"}, rsel2, 0);
    check({tag, " out_pc"}, out_pc, 0);
    check({tag, " rs1_val"}, out_rs1_val, 0);
    check({tag, " imm"}, out_imm, 0);
    check({tag, " rd_wen"}, out_rd_wen, 0);
    check({tag, " opcode"}, out_opcode, 0);
  endtask

  initial begin
    vec_t v;
    logic [4:0] f1, f2;

    //            instr         pc        v1           v2           aw  asel   adat          rw  rsel   rdat          ops e1           e2           ci  imm           rd     wen ill
    vecs[0]  = '{32'h00A08293, 32'h1000, 32'h11,      32'h22,      0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 32'h11,      32'h22,      1, 32'h0000000A, 5'd5,  1, 0};
    vecs[1]  = '{32'h0021A423, 32'h1004, 32'h100,     32'hCAFE,    0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 32'h100,     32'hCAFE,    1, 32'h00000008, 5'd8,  0, 0};
    vecs[2]  = '{32'h00A08293, 32'h1008, 32'h11,      32'h22,      1, 5'd1,  32'h55,       0, 5'd0,  32'h0,        1, 32'h55,      32'h22,      1, 32'h0000000A, 5'd5,  1, 0};
    vecs[3]  = '{32'h00A08293, 32'h100C, 32'h11,      32'h22,      0, 5'd0,  32'h0,        1, 5'd1,  32'h55,       1, 32'h55,      32'h22,      1, 32'h0000000A, 5'd5,  1, 0};
    vecs[4]  = '{32'hFFF00313, 32'h1010, 32'h0,       32'h31,      1, 5'd0,  32'hDEAD,     1, 5'd0,  32'hDEAD,     1, 32'h0,       32'h31,      1, 32'hFFFFFFFF, 5'd6,  1, 0};
    vecs[5]  = '{32'h123453B7, 32'h1014, 32'h0,       32'h0,       0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 32'h0,       32'h0,       1, 32'h12345000, 5'd7,  1, 0};
    vecs[6]  = '{32'hFFFFFFFF, 32'h1018, 32'h31313131,32'h31313131,0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 32'h31313131,32'h31313131,0, 32'h0,        5'd31, 0, 1};
    vecs[7]  = '{32'hFE208CE3, 32'h101C, 32'hA1,      32'hB2,      0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 32'hA1,      32'hB2,      1, 32'hFFFFFFF8, 5'd25, 0, 0};
    vecs[8]  = '{32'h001000EF, 32'h1020, 32'h0,       32'h0,       0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 32'h0,       32'h0,       1, 32'h00000800, 5'd1,  1, 0};
    vecs[9]  = '{32'h402081B3, 32'h1024, 32'h10,      32'h20,      0, 5'd0,  32'h0,        1, 5'd2,  32'h55,       1, 32'h10,      32'h55,      1, 32'h0,        5'd3,  1, 0};
    vecs[10] = '{32'h0000000F, 32'h1028, 32'h0,       32'h0,       0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 32'h0,       32'h0,       1, 32'h0,        5'd0,  0, 0};
    vecs[11] = '{32'hFFC12203, 32'h102C, 32'h200,     32'h28,      0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 32'h200,     32'h28,      1, 32'hFFFFFFFC, 5'd4,  1, 0};
    vecs[12] = '{32'h00A08293, 32'h1030, 32'h11,      32'h22,      1, 5'd1,  32'h55,       1, 5'd1,  32'h66,       1, 32'h66,      32'h22,      1, 32'h0000000A, 5'd5,  1, 0};
    vecs[13] = '{32'h0021A423, 32'h1034, 32'h100,     32'hCAFE,    1, 5'd2,  32'h77,       0, 5'd0,  32'h0,        1, 32'h100,     32'h77,      1, 32'h00000008, 5'd8,  0, 0};

    // Reset state
    #2;
    check_all_zero("reset");
    tick(); tick();
    rst = 1'b1;
    #1;
    check("post-reset in_ready", in_ready, 1);
    check("post-reset out_valid", out_valid, 0);
    tick();

    // Table-driven single-instruction flows
    for (int k = 0; k < NV; k++) begin
      v  = vecs[k];
      f1 = v.instr[19:15];
      f2 = v.instr[24:20];
      wb_write(f1, v.v1);
      wb_write(f2, v.v2);
      offer(v.instr, v.pc);
      wb_wen = v.aw; wb_wsel = v.asel; wb_wdata = v.adat;
      #1;
      check($sformatf("v%0d idle in_ready", k), in_ready, 1);
      check($sformatf("v%0d rsel1", k), rsel1, f1);
      check($sformatf("v%0d rsel2", k), rsel2, f2);
      tick();
      in_valid = 1'b0;
      wb_wen = v.rw; wb_wsel = v.rsel; wb_wdata = v.rdat;
      #1;
      check($sformatf("v%0d read out_valid", k), out_valid, 0);
      check($sformatf("v%0d read in_ready", k), in_ready, 0);
      tick();
      wb_wen = 1'b0;
      #1;
      check($sformatf("v%0d out_valid", k), out_valid, 1);
      check($sformatf("v%0d pc", k), out_pc, v.pc);
      if (v.chk_ops) begin
        check($sformatf("v%0d rs1_val", k), out_rs1_val, v.e1);
        check($sformatf("v%0d rs2_val", k), out_rs2_val, v.e2);
      end
      if (v.chk_imm) check($sformatf("v%0d imm", k), out_imm, v.eimm);
      check($sformatf("v%0d rd", k), out_rd, v.erd);
      check($sformatf("v%0d rd_wen", k), out_rd_wen, v.ewen);
      check($sformatf("v%0d illegal", k), out_illegal, v.eill);
      check($sformatf("v%0d opcode", k), out_opcode, {25'd0, v.instr[6:0]});
      check($sformatf("v%0d funct3", k), out_funct3, {29'd0, v.instr[14:12]});
      check($sformatf("v%0d funct7b5", k), out_funct7b5, {31'd0, v.instr[30]});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("v%0d retired", k), out_valid, 0);
    end

    // Stall in OUT with operand update, then back-to-back accept on retire
    wb_write(5'd1, 32'h11);
    wb_write(5'd10, 32'h22);
    wb_write(5'd3, 32'h100);
    wb_write(5'd2, 32'hCAFE);
    offer(32'h00A08293, 32'h2000);
    tick();
    in_valid = 1'b0;
    tick();
    wb_wen = 1'b1; wb_wsel = 5'd1; wb_wdata = 32'h77;
    tick();
    wb_wen = 1'b0;
    tick();
    check("stall out_valid", out_valid, 1);
    check("stall rs1 updated", out_rs1_val, 32'h77);
    check("stall rs2 stable", out_rs2_val, 32'h22);
    check("stall imm stable", out_imm, 32'h0000000A);
    check("stall pc stable", out_pc, 32'h2000);
    check("stall in_ready", in_ready, 0);
    out_ready = 1'b1;
    offer(32'h0021A423, 32'h2004);
    #1;
    check("b2b in_ready", in_ready, 1);
    check("b2b rsel1", rsel1, 3);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("b2b read out_valid", out_valid, 0);
    tick();
    check("b2b out_valid", out_valid, 1);
    check("b2b pc", out_pc, 32'h2004);
    check("b2b rs1", out_rs1_val, 32'h100);
    check("b2b rs2", out_rs2_val, 32'hCAFE);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Flush in READ
    offer(32'h00A08293, 32'h3000);
    tick();
    in_valid = 1'b0; flush = 1'b1;
    #1;
    check("flushR in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    check("flushR out_valid", out_valid, 0);
    check("flushR idle in_ready", in_ready, 1);
    tick();
    check("flushR still empty", out_valid, 0);

    // Flush overrides accept in IDLE
    offer(32'h00A08293, 32'h3100);
    flush = 1'b1;
    #1;
    check("flush-accept in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick(); tick();
    check("flush-accept no bundle", out_valid, 0);

    // Flush in OUT with out_ready=0
    offer(32'h00A08293, 32'h3200);
    tick();
    in_valid = 1'b0;
    tick();
    check("flushO pre out_valid", out_valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flushO out_valid", out_valid, 0);
    check("flushO idle in_ready", in_ready, 1);

    // Reset pulled mid-READ
    offer(32'h0021A423, 32'h4000);
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_all_zero("rstR");
    tick();
    rst = 1'b1;
    tick(); tick(); tick();
    check("rstR nothing emitted", out_valid, 0);
    check("rstR idle in_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
